// File: rtl/interrupt_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | interrupt_sequencer_if                                               |
// | CPU-facing interrupt bus: instruction word, valid strobe and the     |
// | queue status counters published by the interrupt sequencer.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface interrupt_sequencer_if;
  logic [31:0] interrupt_instruction;
  logic        instr_valid;
  logic [2:0]  queue_level;
  logic [7:0]  dropped_count;

  // The sequencer drives the bus.
  modport master (
    output interrupt_instruction,
    output instr_valid,
    output queue_level,
    output dropped_count
  );

  // The CPU interrupt port and status observers consume it.
  modport slave (
    input interrupt_instruction,
    input instr_valid,
    input queue_level,
    input dropped_count
  );
endinterface
`default_nettype wire

// File: rtl/interrupt_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | interrupt_sequencer                                                  |
// | Synchronises and debounces the jump button and the frame clock,     |
// | queues the resulting events in a 4-entry FIFO and issues them to the |
// | CPU as single-cycle interrupt instructions separated by ISSUE_GAP    |
// | nop cycles.                                                          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module interrupt_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned ISSUE_GAP       = 8,
  parameter logic [31:0] FRAME_INSTR     = 32'h0800_0100,
  parameter logic [31:0] JUMP_INSTR      = 32'h0800_0200
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  jump_key,
  input  logic                  frame_clk,
  interrupt_sequencer_if.master irq_o
);

  // Counter widths are chosen to hold the full parameter value.
  localparam int DEB_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam int GAP_W = (ISSUE_GAP < 1) ? 1 : $clog2(ISSUE_GAP + 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
  // A zero gap still spends one cycle in GAP.
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((ISSUE_GAP == 0) ? 0 : ISSUE_GAP - 1);
  localparam logic [2:0]       DEPTH    = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  // Synchroniser and edge-detect flops
  logic jump_meta_q, jump_sync_q;
  logic frame_meta_q, frame_sync_q, frame_dly_q;
  // Debouncer
  logic             jump_deb_q, jump_deb_dly_q;
  logic [DEB_W-1:0] deb_cnt_q;
  // FIFO: one type bit per entry, 0 = frame, 1 = jump
  logic [3:0] fifo_q, fifo_d;
  logic [1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0] count_q, count_d;
  logic [7:0] dropped_q, dropped_d;
  // Issue FSM
  state_t           state_q, state_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [31:0]      instr_q, instr_d;
  logic             valid_q, valid_d;

  logic       frame_evt, jump_evt, pop;
  logic       push_frame, push_jump;
  logic [2:0] count_mid;
  logic [1:0] n_drop, jump_slot;
  logic [8:0] drop_sum;

  // Two-flop synchronisers on both asynchronous inputs, plus one delay for frame edge detect
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      jump_meta_q  <= 1'b0;
      jump_sync_q  <= 1'b0;
      frame_meta_q <= 1'b0;
      frame_sync_q <= 1'b0;
      frame_dly_q  <= 1'b0;
    end else begin
      jump_meta_q  <= jump_key;
      jump_sync_q  <= jump_meta_q;
      frame_meta_q <= frame_clk;
      frame_sync_q <= frame_meta_q;
      frame_dly_q  <= frame_sync_q;
    end
  end

  assign frame_evt = frame_sync_q & ~frame_dly_q;

  // Debounce: accept a new key level only after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      jump_deb_q     <= 1'b0;
      jump_deb_dly_q <= 1'b0;
      deb_cnt_q      <= '0;
    end else begin
      jump_deb_dly_q <= jump_deb_q;
      if (jump_sync_q == jump_deb_q) begin
        deb_cnt_q <= '0;
      end else if (deb_cnt_q == DEB_LAST) begin
        jump_deb_q <= ~jump_deb_q;
        deb_cnt_q  <= '0;
      end else begin
        deb_cnt_q <= deb_cnt_q + 1'b1;
      end
    end
  end

  // Only the press direction of the debounced key is an event; holding never repeats.
  assign jump_evt = jump_deb_q & ~jump_deb_dly_q;

  // FIFO next state: frame is pushed before jump; the full test sees the occupancy at the
  // start of the cycle plus any earlier push, so a same-cycle pop does not free a slot.
  always_comb begin
    push_frame = frame_evt && (count_q < DEPTH);
    count_mid  = count_q + {2'b00, push_frame};
    push_jump  = jump_evt && (count_mid < DEPTH);
    n_drop     = {1'b0, frame_evt & ~push_frame} + {1'b0, jump_evt & ~push_jump};
    jump_slot  = wr_ptr_q + {1'b0, push_frame};

    fifo_d = fifo_q;
    if (push_frame) fifo_d[wr_ptr_q]  = 1'b0;
    if (push_jump)  fifo_d[jump_slot] = 1'b1;

    wr_ptr_d = wr_ptr_q + {1'b0, push_frame} + {1'b0, push_jump};
    rd_ptr_d = rd_ptr_q + {1'b0, pop};
    count_d  = count_mid + {2'b00, push_jump} - {2'b00, pop};

    drop_sum  = {1'b0, dropped_q} + {7'd0, n_drop};
    dropped_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  // FIFO storage, pointers, occupancy and saturating drop counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fifo_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      dropped_q <= '0;
    end else begin
      fifo_q    <= fifo_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      dropped_q <= dropped_d;
    end
  end

  // Issue FSM next state: pop and load in IDLE, one ISSUE cycle, then ISSUE_GAP nop cycles
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    instr_d = '0;
    valid_d = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (count_q != 3'd0) begin
          pop     = 1'b1;
          instr_d = fifo_q[rd_ptr_q] ? JUMP_INSTR : FRAME_INSTR;
          valid_d = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        gap_d   = '0;
        state_d = S_GAP;
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Issue FSM state and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      gap_q   <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign irq_o.interrupt_instruction = instr_q;
  assign irq_o.instr_valid           = valid_q;
  assign irq_o.queue_level           = count_q;
  assign irq_o.dropped_count         = dropped_q;

endmodule
`default_nettype wire

// File: tb/tb_interrupt_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_interrupt_sequencer                                               |
// | Self-checking bench: vector table, hand-written corner sequences and |
// | random stimulus compared every cycle against an event-level model.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_interrupt_sequencer;
  localparam int          DEB     = 16;
  localparam int          GAP     = 8;
  localparam logic [31:0] FRAME_W = 32'h0800_0100;
  localparam logic [31:0] JUMP_W  = 32'h0800_0200;

  logic clk       = 1'b0;
  logic reset_n   = 1'b0;
  logic jump_key  = 1'b0;
  logic frame_clk = 1'b0;

  interrupt_sequencer_if bus ();

  interrupt_sequencer #(
    .DEBOUNCE_CYCLES(DEB),
    .ISSUE_GAP      (GAP),
    .FRAME_INSTR    (FRAME_W),
    .JUMP_INSTR     (JUMP_W)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .jump_key (jump_key),
    .frame_clk(frame_clk),
    .irq_o    (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n_f   = 0;
  int n_j   = 0;

  typedef struct {
    logic        frame;
    logic        jump;
    logic [31:0] instr;
    logic        valid;
    logic [2:0]  level;
  } vec_t;
  vec_t tbl [19];

  // ---------------- reference model (event level) ----------------
  // Raw input samples are kept as a short history; an event becomes a queue entry
  // at a fixed number of edges after it is sampled. Issue timing is a "next edge
  // at which a pop is allowed" timestamp.
  int          m_edge = 0, m_run = 0, m_next_pop = 0, m_drop = 0;
  logic        f_p1 = 0, f_p2 = 0, f_p3 = 0, j_p1 = 0, j_p2 = 0;
  logic        m_deb = 0, m_jpend = 0;
  logic [31:0] m_instr = '0;
  bit          m_q[$];

  initial begin : ref_model
    int   sz, acc;
    logic fev, jev, do_pop;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_edge = 0; m_run = 0; m_next_pop = 0; m_drop = 0;
        f_p1 = 0; f_p2 = 0; f_p3 = 0; j_p1 = 0; j_p2 = 0;
        m_deb = 0; m_jpend = 0; m_instr = '0;
        m_q.delete();
      end else begin
        m_edge++;
        fev = f_p2 & ~f_p3;
        jev = m_jpend;
        m_jpend = 1'b0;
        if (j_p2 == m_deb) begin
          m_run = 0;
        end else begin
          m_run++;
          if (m_run == DEB) begin
            m_deb   = j_p2;
            m_run   = 0;
            m_jpend = j_p2;
          end
        end
        sz      = m_q.size();
        do_pop  = (sz > 0) && (m_edge >= m_next_pop);
        m_instr = '0;
        if (do_pop) begin
          m_instr    = m_q[0] ? JUMP_W : FRAME_W;
          m_next_pop = m_edge + GAP + 2;
        end
        acc = 0;
        if (fev) begin
          if (sz + acc < 4) begin m_q.push_back(1'b0); acc++; end
          else if (m_drop < 255) m_drop++;
        end
        if (jev) begin
          if (sz + acc < 4) begin m_q.push_back(1'b1); acc++; end
          else if (m_drop < 255) m_drop++;
        end
        if (do_pop) void'(m_q.pop_front());
        f_p3 = f_p2; f_p2 = f_p1; f_p1 = frame_clk;
        j_p2 = j_p1; j_p1 = jump_key;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge and compare every output against the model.
  task automatic tick();
    @(negedge clk);
    check("model_instr", bus.interrupt_instruction, m_instr);
    check("model_valid", 32'(bus.instr_valid), 32'(m_instr != 32'd0));
    check("model_level", 32'(bus.queue_level), 32'(m_q.size()));
    check("model_dropped", 32'(bus.dropped_count), 32'(m_drop));
    if (bus.instr_valid) begin
      if (bus.interrupt_instruction == JUMP_W) n_j++;
      else n_f++;
    end
  endtask

  task automatic check_zero(input string name);
    check({name, "_instr"}, bus.interrupt_instruction, 32'd0);
    check({name, "_valid"}, 32'(bus.instr_valid), 32'd0);
    check({name, "_level"}, 32'(bus.queue_level), 32'd0);
    check({name, "_dropped"}, 32'(bus.dropped_count), 32'd0);
  endtask

  // Called at a falling edge; asserts reset mid low phase, releases at a falling edge.
  task automatic reset_for(input int n);
    #2 reset_n = 1'b0;
    repeat (n) tick();
    reset_n = 1'b1;
  endtask

  // Overflow pattern: rising frame edges sampled at edges 10,12,...,20.
  function automatic logic ovf_frame(input int e);
    return (e >= 10) && (e <= 20) && (e % 2 == 0);
  endfunction

  // ---------------- stimulus ----------------
  initial begin : stim
    int first_e, hold, noise;
    logic target;

    // Vector table: a single frame edge, then a second one after the gap.
    for (int i = 0; i < 19; i++) begin
      tbl[i].frame = 1'b1; tbl[i].jump = 1'b0;
      tbl[i].instr = '0;   tbl[i].valid = 1'b0; tbl[i].level = 3'd0;
    end
    tbl[13].frame = 1'b0;
    tbl[2].level  = 3'd1;
    tbl[3].instr  = FRAME_W; tbl[3].valid = 1'b1;
    tbl[16].level = 3'd1;
    tbl[17].instr = FRAME_W; tbl[17].valid = 1'b1;

    // Reset held with key high and frame toggling.
    jump_key = 1'b1;
    for (int i = 0; i < 10; i++) begin
      frame_clk = ~frame_clk;
      tick();
    end
    check_zero("rst_hold");
    frame_clk = 1'b0;
    reset_n   = 1'b1;
    first_e = 0; n_f = 0; n_j = 0;
    for (int e = 1; e <= 40; e++) begin
      tick();
      if (bus.instr_valid && first_e == 0) first_e = e;
    end
    check("rstkey_jumps", n_j, 1);
    check("rstkey_frames", n_f, 0);
    check("rstkey_latency", first_e, 20);
    jump_key = 1'b0;
    n_j = 0; n_f = 0;
    repeat (30) tick();
    check("release_quiet", n_j + n_f, 0);

    // Table-driven single frame edge.
    frame_clk = 1'b0; jump_key = 1'b0;
    reset_for(3);
    for (int i = 0; i < 19; i++) begin
      frame_clk = tbl[i].frame;
      jump_key  = tbl[i].jump;
      tick();
      check($sformatf("tbl%0d_instr", i), bus.interrupt_instruction, tbl[i].instr);
      check($sformatf("tbl%0d_valid", i), 32'(bus.instr_valid), 32'(tbl[i].valid));
      check($sformatf("tbl%0d_level", i), 32'(bus.queue_level), 32'(tbl[i].level));
    end

    // Bouncing press, hold, bouncing release, fresh press.
    n_j = 0; n_f = 0;
    for (int c = 0; c < 40; c++) begin
      jump_key = ((c / 3) % 2 == 0);
      tick();
    end
    jump_key = 1'b1;
    repeat (60) tick();
    check("bounce_press_jumps", n_j, 1);
    for (int c = 0; c < 40; c++) begin
      jump_key = ((c / 3) % 2 == 1);
      tick();
    end
    jump_key = 1'b0;
    repeat (30) tick();
    check("bounce_release_jumps", n_j, 1);
    jump_key = 1'b1;
    repeat (40) tick();
    check("fresh_press_jumps", n_j, 2);
    check("bounce_frames", n_f, 0);

    // Coincident frame pulse and debounced press.
    frame_clk = 1'b0; jump_key = 1'b1;
    reset_for(3);
    for (int e = 1; e <= 32; e++) begin
      frame_clk = (e >= 17);
      tick();
      if (e == 18) check("coin_level_e18", 32'(bus.queue_level), 32'd0);
      if (e == 19) check("coin_level_e19", 32'(bus.queue_level), 32'd2);
      if (e == 20) check("coin_first", bus.interrupt_instruction, FRAME_W);
      if (e == 29) check("coin_gap", bus.interrupt_instruction, 32'd0);
      if (e == 30) check("coin_second", bus.interrupt_instruction, JUMP_W);
    end

    // Overflow while the FSM is busy: six arrivals, two dropped.
    frame_clk = 1'b0; jump_key = 1'b1;
    reset_for(3);
    n_f = 0; n_j = 0;
    for (int e = 1; e <= 60; e++) begin
      frame_clk = ovf_frame(e);
      tick();
      if (e == 13) check("ovf_lead", bus.interrupt_instruction, FRAME_W);
      if (e == 19) check("ovf_full", 32'(bus.queue_level), 32'd4);
      if (e == 22) check("ovf_dropped", 32'(bus.dropped_count), 32'd2);
      if (e == 23) check("ovf_issue1", bus.interrupt_instruction, FRAME_W);
      if (e == 23) check("ovf_level3", 32'(bus.queue_level), 32'd3);
      if (e == 33) check("ovf_issue2", bus.interrupt_instruction, FRAME_W);
      if (e == 43) check("ovf_issue3", bus.interrupt_instruction, FRAME_W);
      if (e == 53) check("ovf_issue4", bus.interrupt_instruction, JUMP_W);
    end
    check("ovf_frames", n_f, 4);
    check("ovf_jumps", n_j, 1);

    // Drive far more than 255 drops; the counter must saturate.
    for (int i = 0; i < 900; i++) begin
      frame_clk = ~frame_clk;
      tick();
    end
    check("sat_dropped", 32'(bus.dropped_count), 32'd255);
    frame_clk = 1'b0;
    repeat (60) tick();
    check("sat_drained", 32'(bus.queue_level), 32'd0);
    check("sat_hold", 32'(bus.dropped_count), 32'd255);

    // Async reset during GAP with three entries queued.
    frame_clk = 1'b0; jump_key = 1'b1;
    reset_for(3);
    for (int e = 1; e <= 25; e++) begin
      frame_clk = ovf_frame(e);
      tick();
    end
    check("gap_level", 32'(bus.queue_level), 32'd3);
    #2 reset_n = 1'b0;
    #1 check_zero("async_rst");
    jump_key = 1'b0; frame_clk = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    n_f = 0; n_j = 0;
    repeat (40) tick();
    check("no_stale", n_f + n_j, 0);

    // Random frame edges and a bouncing key, checked by the model every cycle.
    frame_clk = 1'b0; jump_key = 1'b0;
    reset_for(3);
    target = 1'b0; hold = 0; noise = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) frame_clk = ~frame_clk;
      if (hold == 0) begin
        target = ~target;
        hold   = int'($urandom_range(5, 60));
        noise  = int'($urandom_range(0, 8));
      end
      jump_key = (noise > 0) ? 1'($urandom_range(0, 1)) : target;
      if (noise > 0) noise--;
      hold--;
      if (i == 1500) begin
        #2 reset_n = 1'b0;
        #1 check_zero("rand_rst");
      end
      if (i == 1503) reset_n = 1'b1;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/interrupt_sequencer.md
Name: interrupt_sequencer

Overview:
- Upstream of the CPU interrupt port: turns the raw jump button and the 60 Hz frame-rate clock into a stream of single-cycle 32-bit interrupt instructions.
- Runs in the processor clock domain. Synchronises and debounces its inputs, queues events in a 4-entry FIFO, and paces issue so the CPU pipeline sees at most one interrupt instruction per ISSUE_GAP+1 cycles.
- Between instructions, interrupt_instruction is 32'd0 (nop).

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable synchronised samples required before a jump_key level change is accepted (10 ms at 50 MHz).
- ISSUE_GAP, 8, nop cycles forced after each issued instruction.
- FRAME_INSTR, 32'h08000100, instruction word issued per frame tick.
- JUMP_INSTR, 32'h08000200, instruction word issued per accepted jump press.

Ports:
- clk  input  1  processor clock. The only clock; all state is on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- jump_key  input  1  raw push-button, asynchronous, active-high.
- frame_clk  input  1  frame-rate clock from the divider, asynchronous to clk. Only rising edges are used.
- interrupt_instruction  output  32  instruction to the CPU interrupt port; 0 when idle.
- instr_valid  output  1  high during the cycle interrupt_instruction is nonzero.
- queue_level  output  3  current FIFO occupancy, 0..4.
- dropped_count  output  8  events lost to a full FIFO; saturates at 255.

Behaviour:
- Reset (async assert, sync release): all outputs 0, FIFO empty, FSM in IDLE, debounced jump state 0, debounce counter 0, synchroniser flops 0.
- Synchronisers: 2-flop synchroniser on each of jump_key and frame_clk. Nothing downstream uses an unsynchronised input.
- Frame event: a 1-cycle pulse when synchronised frame_clk is 1 and its delayed copy is 0.
- Debounce:
  - The counter resets to 0 whenever the synchronised jump_key equals the debounced state.
  - Otherwise it increments. On reaching DEBOUNCE_CYCLES-1 the debounced state toggles and the counter clears.
  - A 0->1 toggle of the debounced state is one jump event. Holding the key gives no repeats; a debounced release is required before the next event.
- FIFO:
  - 4 entries, 1-bit type per entry (0 = frame, 1 = jump). 2-bit read/write pointers wrap modulo 4; 3-bit count.
  - Both events in the same cycle: frame is written first, then jump (two pushes that cycle).
  - Each push that finds the FIFO full (count counted after any earlier push in the same cycle) is dropped and increments dropped_count. Saturates at 255, never wraps.
  - A pop and a push in the same cycle are both performed; count is unchanged.
  - queue_level equals count (registered).
- Issue FSM, 3 states:
  - IDLE: if count > 0, pop the head, load the output register with FRAME_INSTR or JUMP_INSTR by type, assert instr_valid, go to ISSUE. Otherwise hold outputs 0.
  - ISSUE: lasts exactly 1 cycle with the instruction and instr_valid on the outputs. Next edge clears both outputs to 0 and goes to GAP with the gap counter at 0.
  - GAP: outputs 0. Gap counter increments each cycle. After ISSUE_GAP cycles in GAP, go to IDLE. With ISSUE_GAP = 0, GAP lasts one cycle.
  - Back-to-back queued events therefore issue every ISSUE_GAP+2 cycles (ISSUE + GAP + IDLE pop cycle). Output is the word only in ISSUE cycles.
- Latency, empty FIFO and FSM in IDLE: the instruction is visible in the cycle following the 4th rising clk edge counted from the first edge that samples frame_clk high.
  - Edges 1-2: synchroniser.
  - Edge 3: push.
  - Edge 4: pop and output load.
  - Jump latency is the same, counted from the edge where the debounced state toggles, minus the sync stages.
- Reset mid-operation: any queued events and any in-flight instruction are discarded immediately. The output is 0 asynchronously on reset_n low.
- Widths: the gap counter is sized to hold ISSUE_GAP; the debounce counter is sized to hold DEBOUNCE_CYCLES. Both are clog2-based and have no overflow paths.

Test Plan:
- Reset: hold reset_n=0 with jump_key=1 and frame_clk toggling -> all outputs 0. After release, an already-high key with no prior debounced release still yields exactly one jump event after DEBOUNCE_CYCLES.
- Single frame edge (DEBOUNCE_CYCLES=16, ISSUE_GAP=8) -> interrupt_instruction=32'h08000100 with instr_valid=1 for exactly 1 cycle, 4 edges after the first high sample. Outputs are 0 for the following 9 cycles.
- Bounce: jump_key toggling every 3 cycles for 40 cycles, then held high 20 cycles -> exactly one 32'h08000200 issued; no further issue while held. A release bounce followed by a fresh press gives a second issue.
- Coincident events: frame pulse and debounced press in the same cycle -> queue_level goes 0->2. Issue order is FRAME_INSTR then JUMP_INSTR, ISSUE_GAP+2 = 10 cycles apart.
- Overflow: 6 events injected while the FSM is in GAP with the FIFO empty -> queue_level=4, dropped_count=2, four issues in arrival order. Drive 300 overflow drops -> dropped_count=255.
- Async reset asserted during GAP with queue_level=3 -> outputs and queue_level go to 0 immediately. After release, no stale instruction is issued.
